// File: rtl/windowed_mac.sv
// Multi-channel windowed signed MAC: a_i x each b_i lane, summed over window_p beats, one result beat per window.
// Result valid 1 cycle after the final beat; only a final beat stalls, and only while the previous result is unaccepted.
module windowed_mac #(
  parameter int width_in_p  = 12,
  parameter int frac_in_p   = 11,
  parameter int width_out_p = 32,
  parameter int frac_out_p  = 22,
  parameter int channels_p  = 2,
  parameter int window_p    = 44100,
  parameter int saturate_p  = 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              clear_i,
  input  logic [width_in_p-1:0]             a_i,
  input  logic [channels_p*width_in_p-1:0]  b_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic [channels_p*width_out_p-1:0] data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [$clog2(window_p+1)-1:0]     count_o
);

  localparam int shift_lp  = frac_out_p - 2*frac_in_p;
  localparam int prod_w_lp = 2*width_in_p;
  localparam int wide_w_lp = (prod_w_lp + shift_lp > width_out_p) ? prod_w_lp + shift_lp : width_out_p;
  localparam int cnt_w_lp  = $clog2(window_p+1);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(window_p - 1);
  localparam logic signed [width_out_p-1:0] max_lp = {1'b0, {(width_out_p-1){1'b1}}};
  localparam logic signed [width_out_p-1:0] min_lp = {1'b1, {(width_out_p-1){1'b0}}};

  logic [channels_p*width_out_p-1:0] acc_q, acc_d;
  logic [channels_p*width_out_p-1:0] data_q, data_d;
  logic [channels_p*width_out_p-1:0] sum_all;
  logic [channels_p-1:0]             sat_q, sat_d, sat_nxt;
  logic [cnt_w_lp-1:0]               count_q, count_d;
  logic                              valid_q, valid_d;
  logic                              fire;
  logic                              last_beat;
  logic signed [width_in_p-1:0]      a_s;

  assign a_s       = a_i;
  assign last_beat = (count_q == last_cnt_lp);
  assign ready_o   = ~(last_beat & valid_q & ~ready_i);
  assign fire      = valid_i & ready_o;

  for (genvar c = 0; c < channels_p; c++) begin : g_ch
    logic signed [width_in_p-1:0]  b_c;
    logic signed [prod_w_lp-1:0]   prod;
    logic signed [wide_w_lp-1:0]   prod_wide;
    logic signed [width_out_p-1:0] prod_ext;
    logic signed [width_out_p-1:0] acc_c;
    logic        [width_out_p:0]   sum_wide;
    logic signed [width_out_p-1:0] sum_c;
    logic                          ovf;
    logic                          sat_c;

    assign b_c       = b_i[c*width_in_p +: width_in_p];
    assign acc_c     = acc_q[c*width_out_p +: width_out_p];
    assign prod      = prod_w_lp'(a_s) * prod_w_lp'(b_c);
    assign prod_wide = wide_w_lp'(prod) <<< shift_lp;
    assign prod_ext  = prod_wide[width_out_p-1:0];
    // One extra bit exposes signed overflow as a mismatch of the top two bits.
    assign sum_wide  = {acc_c[width_out_p-1], acc_c} + {prod_ext[width_out_p-1], prod_ext};
    assign ovf       = sum_wide[width_out_p] ^ sum_wide[width_out_p-1];

    always_comb begin
      sat_c = sat_q[c];
      sum_c = sum_wide[width_out_p-1:0];
      if (saturate_p != 0) begin
        if (sat_q[c]) begin
          sum_c = acc_c;
        end else if (ovf) begin
          sum_c = sum_wide[width_out_p] ? min_lp : max_lp;
          sat_c = 1'b1;
        end
      end
    end

    assign sum_all[c*width_out_p +: width_out_p] = sum_c;
    assign sat_nxt[c] = sat_c;
  end

  always_comb begin
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q & ~ready_i;
    if (clear_i) begin
      acc_d   = '0;
      sat_d   = '0;
      count_d = '0;
    end else if (fire) begin
      if (last_beat) begin
        data_d  = sum_all;
        valid_d = 1'b1;
        acc_d   = '0;
        sat_d   = '0;
        count_d = '0;
      end else begin
        acc_d   = sum_all;
        sat_d   = sat_nxt;
        count_d = count_q + cnt_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q   <= '0;
      sat_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_windowed_mac.sv
// Directed bench for windowed_mac: one 32-bit saturating instance plus 24-bit saturating and wrapping instances.
module tb_windowed_mac;
  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        clear_i;
  logic [11:0] a_i;
  logic [23:0] b_i;
  logic        valid_i;
  logic        ready_i;

  logic        rdy_m, vld_m;
  logic [63:0] dat_m;
  logic [2:0]  cnt_m;
  logic        rdy_s, vld_s;
  logic [47:0] dat_s;
  logic [2:0]  cnt_s;
  logic        rdy_w, vld_w;
  logic [47:0] dat_w;
  logic [2:0]  cnt_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  windowed_mac #(.window_p(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .clear_i(clear_i), .a_i(a_i), .b_i(b_i),
    .valid_i(valid_i), .ready_o(rdy_m), .data_o(dat_m), .valid_o(vld_m),
    .ready_i(ready_i), .count_o(cnt_m));

  windowed_mac #(.width_out_p(24), .window_p(4), .saturate_p(1)) dut_sat (
    .clk_i(clk), .reset_n_i(reset_n_i), .clear_i(clear_i), .a_i(a_i), .b_i(b_i),
    .valid_i(valid_i), .ready_o(rdy_s), .data_o(dat_s), .valid_o(vld_s),
    .ready_i(ready_i), .count_o(cnt_s));

  windowed_mac #(.width_out_p(24), .window_p(4), .saturate_p(0)) dut_wrap (
    .clk_i(clk), .reset_n_i(reset_n_i), .clear_i(clear_i), .a_i(a_i), .b_i(b_i),
    .valid_i(valid_i), .ready_o(rdy_w), .data_o(dat_w), .valid_o(vld_w),
    .ready_i(ready_i), .count_o(cnt_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents one beat and holds it until the handshake, bounded to 20 cycles.
  task automatic send(input int a, input int b0, input int b1, input logic clr);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    a_i     = 12'(a);
    b_i     = {12'(b1), 12'(b0)};
    clear_i = clr;
    valid_i = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      ok = rdy_m;
      @(posedge clk); #1;
      if (ok) break;
    end
    valid_i = 1'b0;
    clear_i = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(vld_m), 32'd0);
    check("rst_count", 32'(cnt_m), 32'd0);
    check("rst_data0", dat_m[31:0], 32'h0);
    check("rst_data1", dat_m[63:32], 32'h0);
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(rdy_m), 32'd1);

    // Test 1: basic window
    for (int i = 0; i < 3; i++) send(1024, 1024, -1024, 1'b0);
    @(negedge clk);
    check("t1_count3", 32'(cnt_m), 32'd3);
    check("t1_novalid", 32'(vld_m), 32'd0);
    send(1024, 1024, -1024, 1'b0);
    @(negedge clk);
    check("t1_valid", 32'(vld_m), 32'd1);
    check("t1_lane0", dat_m[31:0], 32'h00400000);
    check("t1_lane1", dat_m[63:32], 32'hFFC00000);
    check("t1_count0", 32'(cnt_m), 32'd0);
    @(negedge clk);
    check("t1_consumed", 32'(vld_m), 32'd0);

    // Test 2: saturation and wrap
    for (int i = 0; i < 4; i++) send(-2048, -2048, -2048, 1'b0);
    @(negedge clk);
    check("t2_main0", dat_m[31:0], 32'h01000000);
    check("t2_sat_valid", 32'(vld_s), 32'd1);
    check("t2_sat0", 32'(dat_s[23:0]), 32'h7FFFFF);
    check("t2_sat1", 32'(dat_s[47:24]), 32'h7FFFFF);
    check("t2_wrap_valid", 32'(vld_w), 32'd1);
    check("t2_wrap0", 32'(dat_w[23:0]), 32'h000000);
    check("t2_wrap1", 32'(dat_w[47:24]), 32'h000000);
    check("t2_sat_cnt", 32'({rdy_s, cnt_s}), 32'h8);
    check("t2_wrap_cnt", 32'({rdy_w, cnt_w}), 32'h8);
    @(negedge clk);

    // Test 3: backpressure
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(1024, 1024, -1024, 1'b0);
    for (int i = 0; i < 3; i++) send(1024, 512, -512, 1'b0);
    @(negedge clk);
    check("t3_held_valid", 32'(vld_m), 32'd1);
    check("t3_held_lane0", dat_m[31:0], 32'h00400000);
    check("t3_count3", 32'(cnt_m), 32'd3);
    a_i = 12'(1024); b_i = {12'(-512), 12'(512)}; valid_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t3_stall", 32'(rdy_m), 32'd0);
    check("t3_stall_cnt", 32'(cnt_m), 32'd3);
    check("t3_stable0", dat_m[31:0], 32'h00400000);
    check("t3_stable1", dat_m[63:32], 32'hFFC00000);
    ready_i = 1'b1;
    #1;
    check("t3_unstall", 32'(rdy_m), 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0; ready_i = 1'b0;
    @(negedge clk);
    check("t3_r2_valid", 32'(vld_m), 32'd1);
    check("t3_r2_lane0", dat_m[31:0], 32'h00200000);
    check("t3_r2_lane1", dat_m[63:32], 32'hFFE00000);
    check("t3_r2_count", 32'(cnt_m), 32'd0);
    ready_i = 1'b1;
    @(negedge clk);
    check("t3_drained", 32'(vld_m), 32'd0);

    // Test 4: back-to-back windows
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      a_i = 12'(1024); b_i = {12'(-2048), 12'(256 * (i/4 + 1))}; valid_i = 1'b1;
      @(negedge clk);
      check("t4_ready", 32'(rdy_m), 32'd1);
      if (i > 0 && i % 4 == 0) begin
        check("t4_valid", 32'(vld_m), 32'd1);
        check("t4_lane0", dat_m[31:0], 32'h00100000 * 32'(i/4));
        check("t4_lane1", dat_m[63:32], 32'hFF800000);
      end else begin
        check("t4_idle", 32'(vld_m), 32'd0);
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    @(negedge clk);
    check("t4_last_valid", 32'(vld_m), 32'd1);
    check("t4_last_lane0", dat_m[31:0], 32'h00300000);
    @(negedge clk);

    // Test 5: clear drops the beat it arrives with
    send(1024, 1024, -1024, 1'b0);
    send(1024, 1024, -1024, 1'b1);
    @(negedge clk);
    check("t5_clr_count", 32'(cnt_m), 32'd0);
    for (int i = 0; i < 3; i++) send(1024, 256, -256, 1'b0);
    @(negedge clk);
    check("t5_early", 32'(vld_m), 32'd0);
    send(1024, 256, -256, 1'b0);
    @(negedge clk);
    check("t5_valid", 32'(vld_m), 32'd1);
    check("t5_lane0", dat_m[31:0], 32'h00100000);
    check("t5_lane1", dat_m[63:32], 32'hFFF00000);
    @(negedge clk);

    // Reset mid-window with a result still pending
    ready_i = 1'b0;
    for (int i = 0; i < 6; i++) send(1024, 1024, -1024, 1'b0);
    @(negedge clk);
    check("rm_pending", 32'(vld_m), 32'd1);
    check("rm_count2", 32'(cnt_m), 32'd2);
    reset_n_i = 1'b0;
    #1;
    check("rm_valid", 32'(vld_m), 32'd0);
    check("rm_count", 32'(cnt_m), 32'd0);
    check("rm_data", dat_m[31:0], 32'h0);
    @(posedge clk); #1;
    reset_n_i = 1'b1; ready_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rm_no_result", 32'(vld_m), 32'd0);
    check("rm_count_idle", 32'(cnt_m), 32'd0);
    for (int i = 0; i < 4; i++) send(1024, 256, -256, 1'b0);
    @(negedge clk);
    check("rm_after_valid", 32'(vld_m), 32'd1);
    check("rm_after_lane0", dat_m[31:0], 32'h00100000);
    check("rm_after_lane1", dat_m[63:32], 32'hFFF00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/windowed_mac.md
Name: windowed_mac

Overview:
- Multi-channel windowed multiply-accumulate correlator for the audio path.
- Each accepted sample multiplies one signed reference value (e.g. the sinusoid generator output) by each channel's signed input sample, then adds the product to that channel's accumulator.
- After window_p samples, it publishes all channel sums as one result beat over valid/ready and restarts the next window with no dead cycles.
- Typical consumer: a result register that drives the SSD display.

Parameters:
- width_in_p, 12: signed input width of a_i and of each b_i lane.
- frac_in_p, 11: fractional bits of the inputs.
- width_out_p, 32: signed accumulator and result width per channel.
- frac_out_p, 22: fractional bits of the result. Requires frac_out_p >= 2*frac_in_p.
- channels_p, 2: number of channels (left, right, ...).
- window_p, 44100: samples per window. Requires window_p >= 2.
- saturate_p, 1: 1 = saturating accumulate, 0 = two's-complement wrap.

Ports:
- clk_i, input, 1: the single clock.
- reset_n_i, input, 1: asynchronous, active-low reset.
- clear_i, input, 1: synchronous abort of the current window.
- a_i, input, width_in_p: signed reference sample.
- b_i, input, channels_p*width_in_p: signed channel samples, channel c at [c*width_in_p +: width_in_p].
- valid_i, input, 1: input beat valid.
- ready_o, output, 1: input beat accepted when valid_i & ready_o.
- data_o, output, channels_p*width_out_p: signed results, channel c at [c*width_out_p +: width_out_p].
- valid_o, output, 1: result beat valid.
- ready_i, input, 1: consumer accepts the result.
- count_o, output, $clog2(window_p+1): samples accumulated so far in the current window.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - accumulators, count_o and data_o = 0; valid_o = 0.
  - ready_o = 1 from the first cycle after release.
- Product:
  - full signed product, 2*width_in_p bits.
  - shifted left by frac_out_p - 2*frac_in_p, then sign-extended to width_out_p.
- Accumulate, per channel per accepted beat: acc + product.
  - saturate_p=1: on signed overflow, clamp to the most positive or most negative width_out_p value, and hold there until the window ends.
  - saturate_p=0: wrap.
- count_o increments on each accepted beat.
- Final beat (accepted when count_o == window_p-1):
  - data_o <= acc + product, per channel, with the same saturation rule.
  - valid_o <= 1 the next cycle (latency 1 cycle from the last handshake).
  - accumulators and count_o <= 0 in the same cycle.
  - the next beat accumulates into the new window.
- Output register:
  - data_o is stable while valid_o & ~ready_i.
  - valid_o clears on valid_o & ready_i unless a new result is written in the same cycle; in that case valid_o stays 1 and data_o takes the new value.
- Backpressure:
  - ready_o = ~(count_o == window_p-1 & valid_o & ~ready_i).
  - Only a final beat stalls, and only while the previous result is still unaccepted.
  - All other beats are always accepted.
- clear_i:
  - next cycle: accumulators and count_o = 0.
  - a beat accepted in the same cycle is discarded.
  - a pending result (valid_o, data_o) is unaffected.
- Reset mid-window: all partial sums are lost and no result is emitted.
- valid_i low: state holds. There are no gaps requirements; beats may be sparse.

Test Plan:
1. Basic window: window_p=4, channels_p=2, default widths. Four beats with a_i=1024 (0.5), lane0=1024, lane1=-1024, ready_i=1.
   -> one cycle after beat 4: valid_o=1, data_o lane0=0x00400000, lane1=0xFFC00000. count_o back to 0.
2. Saturation: width_out_p=24, saturate_p=1, window_p=4. Four beats with a_i=b=-2048.
   -> lane result 0x7FFFFF. Same run with saturate_p=0 -> 0x000000.
3. Backpressure: window_p=4, ready_i=0, eight beats presented continuously.
   -> first result held stable; ready_o=0 while the eighth beat is presented.
   -> ready_i pulsed -> first result consumed, eighth beat accepted the same cycle, second result appears next cycle.
   -> no beat lost or duplicated.
4. Back-to-back windows: window_p=4, ready_i=1, 12 beats on consecutive cycles.
   -> ready_o never drops; three result beats, one cycle after beats 4, 8 and 12.
5. clear_i and reset: clear_i asserted with beat 2 of 4.
   -> that beat is dropped; the result covers only the next four beats.
   -> Separately, reset_n_i low mid-window: valid_o=0, count_o=0 immediately, and no result is emitted for the aborted window.
